naive_rle_encoder: RTL
======================

NAIVE_RLE_ENCODER -- requirements
Module: naive_rle_encoder

Interface
REQ-001 Parameter: MAX_RUN, default 255, largest run length carried in one output word; legal range 1..255.
REQ-002 Port: AXIS_ACLK  in  1  sole clock; all state updates on its rising edge.
REQ-003 Port: AXIS_ARESTN  in  1  reset, synchronous, active-low.
REQ-004 Port: S_AXIS_TDATA  in  8  input byte, the case-swapped stream from the compressor stage.
REQ-005 Port: S_AXIS_TKEEP  in  1  accepted and ignored.
REQ-006 Port: S_AXIS_TLAST  in  1  marks the final byte of a packet.
REQ-007 Port: S_AXIS_TVALID  in  1  input beat valid.
REQ-008 Port: S_AXIS_TREADY  out  1  block accepts an input beat this cycle.
REQ-009 Port: M_AXIS_TDATA  out  16  run word; [15:8] = run count (1..MAX_RUN), [7:0] = run byte.
REQ-010 Port: M_AXIS_TKEEP  out  2  constant 2'b11.
REQ-011 Port: M_AXIS_TLAST  out  1  final run word of a packet.
REQ-012 Port: M_AXIS_TVALID  out  1  output word valid.
REQ-013 Port: M_AXIS_TREADY  in  1  downstream accepts the output word.

Function
REQ-014 Input beat accepted iff S_AXIS_TVALID && S_AXIS_TREADY; output word consumed iff M_AXIS_TVALID && M_AXIS_TREADY.
REQ-015 Output slot: single registered stage; "slot free" = !M_AXIS_TVALID || M_AXIS_TREADY.
REQ-016 S_AXIS_TREADY = ARESTN high && state != FLUSH && slot free (combinational).
REQ-017 State machine: IDLE (no open run), ACCUM (open run: run_byte, run_cnt), FLUSH (closed single-byte run pending as final word).
REQ-018 IDLE, accept b with TLAST=0: run_byte=b, run_cnt=1, go to ACCUM; no output.
REQ-019 IDLE, accept b with TLAST=1: emit {8'd1,b} with TLAST=1, stay in IDLE.
REQ-020 ACCUM, accept b == run_byte with run_cnt < MAX_RUN: TLAST=0 -> run_cnt+1, no output; TLAST=1 -> emit {run_cnt+1,b} with TLAST=1, go to IDLE.
REQ-021 ACCUM, accept b != run_byte or run_cnt == MAX_RUN: emit {run_cnt,run_byte} with TLAST=0; run_byte=b, run_cnt=1; go to FLUSH if TLAST=1, else stay in ACCUM.
REQ-022 FLUSH: accepts no input; when slot free, emit {run_cnt,run_byte} with TLAST=1 and go to IDLE.
REQ-023 Latency: a word is valid on M_AXIS the cycle after the accepting or flushing edge; no combinational path from S_AXIS_TDATA to M_AXIS.
REQ-024 While M_AXIS_TVALID=1 and M_AXIS_TREADY=0, M_AXIS_TDATA, M_AXIS_TLAST and M_AXIS_TVALID hold stable.
REQ-025 When a word is consumed and no new word is emitted in the same cycle, M_AXIS_TVALID goes to 0 on the next edge.
REQ-026 Emitting a new word in the same cycle the previous word is consumed is allowed; there are no bubbles.
REQ-027 Runs never span packets; every packet produces at least one word, and its last word carries TLAST=1.
REQ-028 run_cnt is 8 bits and never exceeds MAX_RUN; a count of 0 is never emitted.

Reset
REQ-029 ARESTN low at an edge: state=IDLE, run_cnt=0, run_byte=0, M_AXIS_TVALID=0, M_AXIS_TDATA=0, M_AXIS_TLAST=0.
REQ-030 While ARESTN is low, S_AXIS_TREADY=0; M_AXIS_TKEEP stays 2'b11.
REQ-031 Reset mid-packet or mid-FLUSH discards the open run and any pending word; nothing of it is emitted after reset.

Verification
REQ-032 Input 0x41,0x41,0x41,0x42(last), M ready held -> 0x0341 last0, then 0x0142 last1.
REQ-033 Single byte 0x61(last) -> one word 0x0161 last1; S_AXIS_TREADY stays 1.
REQ-034 300 x 0x20 with last on the 300th, MAX_RUN=255 -> 0xFF20 last0, then 0x2D20 last1.
REQ-035 Input 0x41,0x42(last) -> 0x0141 last0, then 0x0142 last1; S_AXIS_TREADY=0 for exactly one cycle (FLUSH) with M ready.
REQ-036 Pending word with M_AXIS_TREADY low for 5 cycles -> TDATA/TLAST stable, S_AXIS_TREADY=0 throughout; no word lost or duplicated afterwards.
REQ-037 Reset after 0x43,0x43 accepted -> no output; next packet 0x44(last) -> 0x0144 last1.

Source files
------------

// File: rtl/naive_rle_encoder_if.sv
// Single-beat AXI-Stream bundle. Both sides of the run-length encoder use it.
// The master drives tdata, tkeep, tlast and tvalid. The slave drives tready.
interface naive_rle_encoder_if #(
  parameter int DATA_W = 8,
  parameter int KEEP_W = 1
);
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport master (
    output tdata, tkeep, tlast, tvalid,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tlast, tvalid,
    output tready
  );
endinterface

// File: rtl/naive_rle_encoder.sv
// Byte-stream run-length encoder. Each output word is {count, byte}, and runs close at packet ends.
// The output is one registered slot. A single-byte run still open at packet end is flushed one cycle later.
module naive_rle_encoder #(
  parameter int MAX_RUN = 255
) (
  input  logic                AXIS_ACLK,
  input  logic                AXIS_ARESTN,
  naive_rle_encoder_if.slave  s_axis,
  naive_rle_encoder_if.master m_axis
);

  typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_t;

  localparam logic [7:0] MAX_CNT = 8'(MAX_RUN);

  state_t      state, state_nxt;
  logic [7:0]  run_byte, run_byte_nxt;
  logic [7:0]  run_cnt, run_cnt_nxt;

  logic [15:0] out_data;
  logic        out_last;
  logic        out_valid;

  logic        emit;
  logic [15:0] emit_data;
  logic        emit_last;

  logic        slot_free;
  logic        accept;
  logic        same_byte;

  // tkeep on the input side carries no information for a byte stream.
  logic unused_keep;
  assign unused_keep = ^s_axis.tkeep;

  assign slot_free     = !out_valid || m_axis.tready;
  assign s_axis.tready = AXIS_ARESTN && (state != FLUSH) && slot_free;
  assign accept        = s_axis.tvalid && s_axis.tready;
  assign same_byte     = (s_axis.tdata == run_byte) && (run_cnt < MAX_CNT);

  assign m_axis.tdata  = out_data;
  assign m_axis.tlast  = out_last;
  assign m_axis.tvalid = out_valid;
  assign m_axis.tkeep  = 2'b11;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt    = state;
    run_byte_nxt = run_byte;
    run_cnt_nxt  = run_cnt;
    emit         = 1'b0;
    emit_data    = 16'h0000;
    emit_last    = 1'b0;

    unique case (state)
      IDLE: begin
        if (accept) begin
          if (s_axis.tlast) begin
            emit      = 1'b1;
            emit_data = {8'd1, s_axis.tdata};
            emit_last = 1'b1;
          end else begin
            run_byte_nxt = s_axis.tdata;
            run_cnt_nxt  = 8'd1;
            state_nxt    = ACCUM;
          end
        end
      end

      ACCUM: begin
        if (accept) begin
          if (same_byte) begin
            if (s_axis.tlast) begin
              emit        = 1'b1;
              emit_data   = {run_cnt + 8'd1, s_axis.tdata};
              emit_last   = 1'b1;
              run_cnt_nxt = 8'd0;
              state_nxt   = IDLE;
            end else begin
              run_cnt_nxt = run_cnt + 8'd1;
            end
          end else begin
            // Close the current run. The new byte either opens the next run or is the packet's last byte.
            emit         = 1'b1;
            emit_data    = {run_cnt, run_byte};
            emit_last    = 1'b0;
            run_byte_nxt = s_axis.tdata;
            run_cnt_nxt  = 8'd1;
            state_nxt    = s_axis.tlast ? FLUSH : ACCUM;
          end
        end
      end

      FLUSH: begin
        if (slot_free) begin
          emit        = 1'b1;
          emit_data   = {run_cnt, run_byte};
          emit_last   = 1'b1;
          run_cnt_nxt = 8'd0;
          state_nxt   = IDLE;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments, so every flop samples pre-edge values.
  always_ff @(posedge AXIS_ACLK) begin
    if (!AXIS_ARESTN) begin
      state    <= IDLE;
      run_byte <= 8'h00;
      run_cnt  <= 8'h00;
    end else begin
      state    <= state_nxt;
      run_byte <= run_byte_nxt;
      run_cnt  <= run_cnt_nxt;
    end
  end

  // The output slot loads whenever a word is emitted. It empties only when it is consumed and nothing replaces it.
  always_ff @(posedge AXIS_ACLK) begin
    if (!AXIS_ARESTN) begin
      out_data  <= 16'h0000;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (emit) begin
      out_data  <= emit_data;
      out_last  <= emit_last;
      out_valid <= 1'b1;
    end else if (m_axis.tready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
